// File: rtl/inst_mem_rsp.sv
// Instruction-memory responder: a combinational fetch port for the core and a
// valid/ready program-load engine that fills the array after reset. The core
// stays held until the final program word is accepted.
module inst_mem_rsp #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           addr_i,
  output logic [31:0]           inst_o,
  input  logic                  load_valid_i,
  input  logic [31:0]           load_data_i,
  input  logic                  load_last_i,
  output logic                  load_ready_o,
  output logic                  cpu_hold_o,
  output logic [DEPTH_LOG2:0]   load_count_o,
  output logic                  fetch_err_o,
  output logic                  ovf_err_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Count value meaning "array full"; the extra count bit holds exactly DEPTH.
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {
    LOAD  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH];

  logic                  transfer;
  logic                  cnt_full;
  logic                  wr_en;
  logic                  addr_ok;
  logic                  fetch_hit;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;

  assign transfer = (state == LOAD) && load_valid_i;
  assign cnt_full = (load_count_o == FULL_CNT);
  // Gated with rst so a word offered while reset is held never lands in the array.
  assign wr_en    = transfer && !cnt_full && rst;
  assign wr_idx   = load_count_o[DEPTH_LOG2-1:0];

  // A fetch is only valid when word-aligned and inside the array's address window.
  assign addr_ok   = (addr_i[1:0] == 2'b00) && (addr_i[31:DEPTH_LOG2+2] == '0);
  assign fetch_hit = (state == READY) && ce_i && addr_ok;
  assign rd_idx    = addr_i[DEPTH_LOG2+1:2];

  // State register; reset always restarts a fresh program load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_next;
  end

  // Next-state and handshake outputs; READY is terminal until reset.
  always_comb begin
    state_next   = state;
    load_ready_o = 1'b0;
    cpu_hold_o   = 1'b0;
    case (state)
      LOAD: begin
        load_ready_o = 1'b1;
        cpu_hold_o   = 1'b1;
        if (load_valid_i && load_last_i) state_next = READY;
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Load counter (saturating at DEPTH) and the sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count_o <= '0;
      fetch_err_o  <= 1'b0;
      ovf_err_o    <= 1'b0;
    end else begin
      if (transfer) begin
        if (cnt_full) ovf_err_o    <= 1'b1;
        else          load_count_o <= load_count_o + 1'b1;
      end
      if ((state == READY) && ce_i && !addr_ok) fetch_err_o <= 1'b1;
    end
  end

  // Program array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= load_data_i;
  end

  // Zero-latency fetch; anything that is not a clean hit returns the NOP word.
  always_comb begin
    inst_o = NOP_WORD;
    if (fetch_hit) inst_o = mem[rd_idx];
  end

endmodule

// File: tb/tb_inst_mem_rsp.sv
// Directed bench for inst_mem_rsp with a reference model and fetch scoreboard.
module tb_inst_mem_rsp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] inst_o;
  logic        load_valid_i = 1'b0;
  logic [31:0] load_data_i = '0;
  logic        load_last_i = 1'b0;
  logic        load_ready_o;
  logic        cpu_hold_o;
  logic [10:0] load_count_o;
  logic        fetch_err_o;
  logic        ovf_err_o;

  inst_mem_rsp #(.DEPTH_LOG2(10), .NOP_WORD(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .load_valid_i (load_valid_i),
    .load_data_i  (load_data_i),
    .load_last_i  (load_last_i),
    .load_ready_o (load_ready_o),
    .cpu_hold_o   (cpu_hold_o),
    .load_count_o (load_count_o),
    .fetch_err_o  (fetch_err_o),
    .ovf_err_o    (ovf_err_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [1024];
  int          mcount;
  bit          mready, mferr, movf;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mcount = 0; mready = 0; mferr = 0; movf = 0;
  endtask

  task automatic chk_ctrl(string tag);
    chk({tag, "_cnt"},   32'(load_count_o), 32'(mcount));
    chk({tag, "_hold"},  32'(cpu_hold_o),   32'(!mready));
    chk({tag, "_ready"}, 32'(load_ready_o), 32'(!mready));
    chk({tag, "_ferr"},  32'(fetch_err_o),  32'(mferr));
    chk({tag, "_ovf"},   32'(ovf_err_o),    32'(movf));
  endtask

  // One rising edge with the currently driven inputs; the model follows it.
  task automatic tick();
    @(posedge clk);
    if (!mready && load_valid_i) begin
      if (mcount < 1024) begin
        mdl[mcount] = load_data_i;
        mcount++;
      end else begin
        movf = 1;
      end
      if (load_last_i) mready = 1;
    end else if (mready && ce_i && !(addr_i[1:0] == 2'b00 && addr_i[31:12] == 20'h0)) begin
      mferr = 1;
    end
    #1;
  endtask

  // Combinational fetch check: expected word is queued at drive time, popped on sample.
  task automatic fetch(string tag, logic ce, logic [31:0] a);
    ce_i = ce;
    addr_i = a;
    if (mready && ce && a[1:0] == 2'b00 && a[31:12] == 20'h0) exp_q.push_back(mdl[a[11:2]]);
    else exp_q.push_back(32'h0000_0000);
    #1;
    chk(tag, inst_o, exp_q.pop_front());
  endtask

  task automatic load(logic v, logic [31:0] d, logic l);
    load_valid_i = v;
    load_data_i  = d;
    load_last_i  = l;
    tick();
  endtask

  task automatic do_reset(string tag);
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    ce_i = 1'b0;
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk_ctrl(tag);
    fetch({tag, "_inst"}, 1'b1, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 1024; i++) mdl[i] = 32'h0;
    // Reset state and three-word program load
    #2;
    chk_ctrl("por");
    @(posedge clk); #1;
    do_reset("t1rst");
    load(1'b1, 32'h2401_0001, 1'b0); chk_ctrl("t1w1");
    load(1'b1, 32'h2402_0002, 1'b0); chk_ctrl("t1w2");
    load(1'b1, 32'h0022_1821, 1'b1); chk_ctrl("t1w3");
    load_valid_i = 1'b0; load_last_i = 1'b0;
    fetch("t1f0", 1'b1, 32'h0);
    fetch("t1f4", 1'b1, 32'h4);
    fetch("t1f8", 1'b1, 32'h8);
    fetch("t1f8_noce", 1'b0, 32'h8);
    tick(); chk_ctrl("t1idle");

    // Bad fetches in READY set a sticky error
    fetch("t3mis", 1'b1, 32'h2);
    tick(); chk_ctrl("t3mis");
    fetch("t3oor", 1'b1, 32'h1000);
    tick(); chk_ctrl("t3oor");
    fetch("t3good", 1'b1, 32'h4);
    tick(); chk_ctrl("t3good");

    // Fetch during LOAD with a pre-filled array
    do_reset("t2rst");
    fetch("t2load_f0", 1'b1, 32'h0);
    tick(); chk_ctrl("t2load");
    fetch("t2load_mis", 1'b1, 32'h2);
    tick(); chk_ctrl("t2load_mis");
    ce_i = 1'b0;

    // Gapped valid: only valid cycles write
    load(1'b1, 32'h1111_AAAA, 1'b0); chk_ctrl("t5a");
    load(1'b0, 32'h5555_5555, 1'b1); chk_ctrl("t5gap");
    load(1'b1, 32'h2222_BBBB, 1'b1); chk_ctrl("t5b");
    load(1'b0, 32'h6666_6666, 1'b1); chk_ctrl("t5end");
    fetch("t5f0", 1'b1, 32'h0);
    fetch("t5f1", 1'b1, 32'h4);
    fetch("t5f2", 1'b1, 32'h8);

    // Asynchronous reset mid-load, then a shorter reload
    do_reset("t6rst0");
    for (int i = 0; i < 5; i++) load(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0);
    chk_ctrl("t6five");
    load_valid_i = 1'b0;
    #2;
    do_reset("t6rst");
    load(1'b1, 32'h7777_0000, 1'b0);
    load(1'b1, 32'h7777_0001, 1'b1); chk_ctrl("t6reload");
    load_valid_i = 1'b0; load_last_i = 1'b0;
    for (int i = 0; i < 5; i++) fetch($sformatf("t6f%0d", i), 1'b1, 32'(i * 4));

    // Overflow: 1025 words into a 1024-word array
    do_reset("t4rst");
    for (int i = 0; i < 1024; i++) load(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    chk_ctrl("t4full");
    load(1'b1, 32'hDEAD_BEEF, 1'b1); chk_ctrl("t4ovf");
    load_valid_i = 1'b0; load_last_i = 1'b0;
    chk("t4mem0", mdl[0], 32'hA000_0000);
    fetch("t4f0", 1'b1, 32'h0);
    fetch("t4flast", 1'b1, 32'hFFC);
    fetch("t4foor", 1'b1, 32'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
